// File: rtl/fixed_mac_acc_if.sv
// Valid/ready term input and result output bundle for the fixed-point MAC accumulator.
interface fixed_mac_acc_if;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        in_ovf;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_ovf;

    // Producer/consumer side: feeds terms and takes results.
    modport master (
        output in_valid, in_data, in_ovf, out_ready,
        input  in_ready, out_valid, out_data, out_ovf
    );

    // Accumulator side.
    modport slave (
        input  in_valid, in_data, in_ovf, out_ready,
        output in_ready, out_valid, out_data, out_ovf
    );
endinterface

// File: rtl/fixed_mac_acc.sv
// Accumulates LEN unsigned 8.8 product terms into one 16-bit result with a sticky
// overflow flag. Results are held until the consumer takes them.
module fixed_mac_acc #(
    parameter int LEN      = 4,
    parameter bit SATURATE = 1'b1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           clear,
    fixed_mac_acc_if.slave bus,
    output logic           busy
);
    localparam logic [7:0] LAST = 8'(LEN - 1);

    typedef enum logic {
        ACC  = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] acc_q, acc_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        ovf_q, ovf_d;
    logic        accept;
    logic [16:0] sum17;
    logic        ovf_next;

    // State and datapath registers; reset wins over everything else.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ACC;
            acc_q   <= 16'h0000;
            cnt_q   <= 8'd0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    // Next state and next accumulator: clear beats the handshakes, the held sum stays frozen in HOLD.
    always_comb begin
        accept   = bus.in_valid && (state_q == ACC);
        sum17    = {1'b0, acc_q} + {1'b0, bus.in_data};
        ovf_next = ovf_q | sum17[16] | bus.in_ovf;
        state_d  = state_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        ovf_d    = ovf_q;
        if (clear) begin
            state_d = ACC;
            acc_d   = 16'h0000;
            cnt_d   = 8'd0;
            ovf_d   = 1'b0;
        end else if (state_q == HOLD) begin
            if (bus.out_ready) begin
                state_d = ACC;
                acc_d   = 16'h0000;
                cnt_d   = 8'd0;
                ovf_d   = 1'b0;
            end
        end else if (accept) begin
            acc_d = (SATURATE && ovf_next) ? 16'hFFFF : sum17[15:0];
            ovf_d = ovf_next;
            if (cnt_q == LAST) begin
                state_d = HOLD;
                cnt_d   = 8'd0;
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
        end
    end

    // Outputs are pure decodes of registered state, so nothing combinational reaches them.
    always_comb begin
        bus.in_ready  = (state_q == ACC);
        bus.out_valid = (state_q == HOLD);
        bus.out_data  = acc_q;
        bus.out_ovf   = ovf_q;
        busy          = (state_q == HOLD) || (cnt_q != 8'd0);
    end
endmodule

// File: tb/tb_fixed_mac_acc.sv
// Bench for fixed_mac_acc: a saturating LEN=4 instance and a wrapping LEN=2 instance,
// driven by directed and random results and compared against a whole-result sum model.
module tb_fixed_mac_acc;
    typedef struct {
        logic [15:0] d;
        logic        o;
    } term_t;
    typedef term_t term_list_t[$];

    logic clk = 1'b0;
    logic rst_n;
    logic clear;
    logic busy_s;
    logic busy_w;
    int   assert_count = 0;
    int   fail_count   = 0;

    fixed_mac_acc_if ifs ();
    fixed_mac_acc_if ifw ();

    fixed_mac_acc #(.LEN(4), .SATURATE(1'b1)) dut_s (
        .clk(clk), .rst_n(rst_n), .clear(clear), .bus(ifs.slave), .busy(busy_s)
    );
    fixed_mac_acc #(.LEN(2), .SATURATE(1'b0)) dut_w (
        .clk(clk), .rst_n(rst_n), .clear(clear), .bus(ifw.slave), .busy(busy_w)
    );

    // Free-running 10-unit clock.
    always #5 clk = ~clk;

    function automatic int lenOf(input int sel);
        return (sel == 0) ? 4 : 2;
    endfunction

    function automatic bit satOf(input int sel);
        return (sel == 0);
    endfunction

    function automatic logic [15:0] getReady(input int sel);
        return {15'd0, (sel == 0) ? ifs.in_ready : ifw.in_ready};
    endfunction

    function automatic logic [15:0] getValid(input int sel);
        return {15'd0, (sel == 0) ? ifs.out_valid : ifw.out_valid};
    endfunction

    function automatic logic [15:0] getData(input int sel);
        return (sel == 0) ? ifs.out_data : ifw.out_data;
    endfunction

    function automatic logic [15:0] getOvf(input int sel);
        return {15'd0, (sel == 0) ? ifs.out_ovf : ifw.out_ovf};
    endfunction

    function automatic logic [15:0] getBusy(input int sel);
        return {15'd0, (sel == 0) ? busy_s : busy_w};
    endfunction

    // Whole-result model: the true sum of all terms decides carry, flags are OR-ed.
    function automatic void refResult(input term_list_t t, input bit sat,
                                      output logic [15:0] d, output logic o);
        int total = 0;
        bit flag  = 1'b0;
        foreach (t[i]) begin
            total += int'(t[i].d);
            flag  |= t[i].o;
        end
        o = flag || (total > 65535);
        d = (sat && o) ? 16'hFFFF : total[15:0];
    endfunction

    function automatic term_list_t mkList(input logic [15:0] d0, d1, d2, d3,
                                          input logic o0, input int n);
        term_list_t l;
        logic [15:0] ds[4];
        ds = '{d0, d1, d2, d3};
        for (int i = 0; i < n; i++) l.push_back('{ds[i], (i == 0) ? o0 : 1'b0});
        return l;
    endfunction

    task automatic stepCycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic applyStimulus(input int sel, input logic v, input logic [15:0] d,
                                 input logic o, input logic r);
        if (sel == 0) begin
            ifs.in_valid = v; ifs.in_data = d; ifs.in_ovf = o; ifs.out_ready = r;
        end else begin
            ifw.in_valid = v; ifw.in_data = d; ifw.in_ovf = o; ifw.out_ready = r;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        assert_count++;
        assert (obs === exp) else begin
            fail_count++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic checkReset(input int sel);
        checkOutput("rst_in_ready", getReady(sel), 16'd1);
        checkOutput("rst_out_valid", getValid(sel), 16'd0);
        checkOutput("rst_out_data", getData(sel), 16'h0000);
        checkOutput("rst_out_ovf", getOvf(sel), 16'd0);
        checkOutput("rst_busy", getBusy(sel), 16'd0);
    endtask

    task automatic sendTerms(input int sel, input term_list_t l);
        foreach (l[i]) begin
            applyStimulus(sel, 1'b1, l[i].d, l[i].o, 1'b0);
            stepCycle();
        end
        applyStimulus(sel, 1'b0, 16'h0000, 1'b0, 1'b0);
    endtask

    // One full result: terms with gaps, a held result under backpressure, then the handshake.
    task automatic runResult(input int sel, input term_list_t l, input int gap, input int hold);
        logic [15:0] exp_d;
        logic        exp_o;
        refResult(l, satOf(sel), exp_d, exp_o);
        foreach (l[i]) begin
            checkOutput("in_ready_acc", getReady(sel), 16'd1);
            applyStimulus(sel, 1'b1, l[i].d, l[i].o, 1'b0);
            stepCycle();
            checkOutput("busy_acc", getBusy(sel), 16'd1);
            if (i != l.size() - 1) begin
                checkOutput("out_valid_early", getValid(sel), 16'd0);
                applyStimulus(sel, 1'b0, 16'h0000, 1'b0, 1'b0);
                repeat (gap) stepCycle();
            end
        end
        checkOutput("out_valid", getValid(sel), 16'd1);
        checkOutput("out_data", getData(sel), exp_d);
        checkOutput("out_ovf", getOvf(sel), {15'd0, exp_o});
        checkOutput("in_ready_hold", getReady(sel), 16'd0);
        repeat (hold) begin
            applyStimulus(sel, 1'b1, 16'($urandom), 1'b0, 1'b0);
            stepCycle();
            checkOutput("hold_valid", getValid(sel), 16'd1);
            checkOutput("hold_data", getData(sel), exp_d);
            checkOutput("hold_ready", getReady(sel), 16'd0);
        end
        applyStimulus(sel, 1'b1, 16'($urandom), 1'b0, 1'b1);
        stepCycle();
        applyStimulus(sel, 1'b0, 16'h0000, 1'b0, 1'b0);
        checkOutput("post_valid", getValid(sel), 16'd0);
        checkOutput("post_ready", getReady(sel), 16'd1);
        checkOutput("post_busy", getBusy(sel), 16'd0);
    endtask

    // Directed sequence followed by random results on both instances.
    initial begin
        term_list_t l;
        rst_n = 1'b0;
        clear = 1'b0;
        applyStimulus(0, 1'b0, 16'h0000, 1'b0, 1'b0);
        applyStimulus(1, 1'b0, 16'h0000, 1'b0, 1'b0);
        stepCycle();
        stepCycle();
        checkReset(0);
        checkReset(1);
        rst_n = 1'b1;
        stepCycle();

        runResult(0, mkList(16'h0100, 16'h0100, 16'h0100, 16'h0100, 1'b0, 4), 0, 5);
        runResult(0, mkList(16'h8000, 16'h8000, 16'h0001, 16'h0001, 1'b0, 4), 0, 0);
        runResult(1, mkList(16'h8000, 16'h8002, 16'h0000, 16'h0000, 1'b0, 2), 0, 1);
        runResult(1, mkList(16'h0080, 16'h0080, 16'h0000, 16'h0000, 1'b1, 2), 0, 0);
        runResult(0, mkList(16'h0080, 16'h0080, 16'h0000, 16'h0000, 1'b1, 4), 0, 0);
        runResult(0, mkList(16'h0200, 16'h0300, 16'h0400, 16'h0100, 1'b0, 4), 2, 0);

        sendTerms(0, mkList(16'h0100, 16'h0100, 16'h0000, 16'h0000, 1'b0, 2));
        clear = 1'b1;
        applyStimulus(0, 1'b1, 16'h7777, 1'b0, 1'b0);
        stepCycle();
        clear = 1'b0;
        applyStimulus(0, 1'b0, 16'h0000, 1'b0, 1'b0);
        checkOutput("clear_busy", getBusy(0), 16'd0);
        checkOutput("clear_ready", getReady(0), 16'd1);
        runResult(0, mkList(16'h0010, 16'h0010, 16'h0010, 16'h0010, 1'b0, 4), 0, 0);

        sendTerms(0, mkList(16'h0100, 16'h0100, 16'h0000, 16'h0000, 1'b1, 2));
        rst_n = 1'b0;
        applyStimulus(0, 1'b1, 16'h7777, 1'b0, 1'b0);
        stepCycle();
        rst_n = 1'b1;
        applyStimulus(0, 1'b0, 16'h0000, 1'b0, 1'b0);
        checkReset(0);
        runResult(0, mkList(16'h0010, 16'h0010, 16'h0010, 16'h0010, 1'b0, 4), 1, 0);

        sendTerms(0, mkList(16'h1000, 16'h1000, 16'h1000, 16'h1000, 1'b1, 4));
        checkOutput("held_valid", getValid(0), 16'd1);
        clear = 1'b1;
        stepCycle();
        clear = 1'b0;
        checkOutput("clear_hold_valid", getValid(0), 16'd0);
        checkOutput("clear_hold_ovf", getOvf(0), 16'd0);
        checkOutput("clear_hold_busy", getBusy(0), 16'd0);

        for (int sel = 0; sel < 2; sel++) begin
            for (int r = 0; r < 8; r++) begin
                l.delete();
                for (int k = 0; k < lenOf(sel); k++) begin
                    term_t t;
                    t.d = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 16'h0FFF));
                    t.o = ($urandom_range(0, 7) == 0);
                    l.push_back(t);
                end
                runResult(sel, l, $urandom_range(0, 2), $urandom_range(0, 3));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end
endmodule

// File: doc/fixed_mac_acc.md
# fixed_mac_acc

Sequential accumulator that sits directly downstream of `fixed_multi`. It consumes a stream of 16-bit unsigned 8.8 fixed-point products and their overflow flags. It sums a fixed number of terms per dot product and presents each completed sum with a sticky overflow flag. Input and output use valid/ready handshakes, so it can sit between a product pipeline and a slower consumer.

## Interface
- `LEN`, 4: terms per accumulated result; legal range 1..255.
- `SATURATE`, 1: 1 = clamp to 16'hFFFF on overflow; 0 = wrap modulo 2^16.

- `clk` in 1: single clock, all state updates on rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `clear` in 1: synchronous abort; discards partial or held result.
- `in_valid` in 1: `in_data`/`in_ovf` are valid.
- `in_ready` out 1: block accepts a term this cycle.
- `in_data` in 16: product term, 8.8 unsigned.
- `in_ovf` in 1: upstream multiplier overflow for this term.
- `out_valid` out 1: `out_data`/`out_ovf` hold a completed result.
- `out_ready` in 1: consumer takes the result this cycle.
- `out_data` out 16: accumulated sum, 8.8 unsigned.
- `out_ovf` out 1: any term overflowed, or any addition carried out of bit 15.
- `busy` out 1: at least one term accepted for the current result, or a result held.

## Operation
- The FSM has two states.
  - ACC: `in_ready`=1, `out_valid`=0.
  - HOLD: `in_ready`=0, `out_valid`=1.
- A term is accepted when `in_valid` && `in_ready`.
- For each accepted term:
  - sum17 = {1'b0,acc} + in_data.
  - ovf_next = ovf | sum17[16] | in_ovf.
  - If SATURATE && ovf_next, acc = 16'hFFFF. Once saturated, acc stays 16'hFFFF for the rest of the result.
  - Otherwise acc = sum17[15:0].
  - cnt increments.
- When a term is accepted with cnt == LEN-1, the FSM goes to HOLD.
  - out_data = the new acc; out_ovf = ovf_next.
- In HOLD, `out_data`/`out_ovf` are stable while `out_ready`=0.
- On `out_ready`=1 in HOLD, the FSM goes to ACC with acc=0, cnt=0, ovf=0.
- `clear`=1 returns the FSM to ACC with acc=0, cnt=0, ovf=0 from any state.
  - A term presented in the same cycle is dropped.
  - A held result is discarded.
- `busy` = (state==HOLD) | (cnt!=0).
- cnt width is 8 bits. cnt never wraps; it is reset on the transition to HOLD.

## Timing
- Reset values when `rst_n`=0 at a clock edge: state ACC; acc 0; cnt 0.
  - Outputs: `in_ready` 1, `out_valid` 0, `out_data` 16'h0000, `out_ovf` 0, `busy` 0.
- Reset priority: rst_n > clear > handshake. Reset mid-accumulation or in HOLD discards everything.
- Throughput: one term per cycle in ACC.
- Latency: `out_valid` rises on the cycle after the edge that accepts term LEN.
- There is one bubble per result: `in_ready` is 0 in HOLD, including the cycle `out_ready` is high. ACC resumes on the next cycle.
- LEN=1: each accepted term becomes a result. Maximum rate is one result per 2 cycles with `out_ready` tied high.
- `in_ready` and `out_valid` are registered state decodes. There is no combinational path from `out_ready` or `in_valid` to any output.
- `out_data` is registered, not a combinational sum.

## Test plan
- Basic sum, LEN=4: four terms of 16'h0100 (1.0) back-to-back -> `out_valid` one cycle after the 4th accept; `out_data`=16'h0400, `out_ovf`=0; `busy` high from the 1st accept until the handshake.
- Carry out, SATURATE=1, LEN=4: terms 16'h8000, 16'h8000, 16'h0001, 16'h0001.
  - Expect `out_data`=16'hFFFF, `out_ovf`=1.
  - Repeat with SATURATE=0: expect `out_data`=16'h0002, `out_ovf`=1.
- Upstream flag, LEN=2: terms 16'h0080 with in_ovf=1, then 16'h0080 with in_ovf=0 -> `out_ovf`=1.
  - With SATURATE=1: `out_data`=16'hFFFF.
  - With SATURATE=0: `out_data`=16'h0100.
- Backpressure: hold `out_ready`=0 for 5 cycles after a result.
  - `out_data`/`out_valid` stay stable; `in_ready`=0; `in_valid` terms are not counted.
  - Raise `out_ready`: next cycle `in_ready`=1; the next result is correct and independent of the previous one.
- Gaps, LEN=3: terms 16'h0200, 16'h0300, 16'h0400 separated by 2-cycle `in_valid`=0 gaps -> `out_data`=16'h0900.
- Abort: after 2 of 4 terms, assert `clear` together with `in_valid`.
  - Next cycle: `busy`=0; the term is dropped.
  - Then four 16'h0010 terms -> `out_data`=16'h0040.
  - Repeat using `rst_n`=0 instead of `clear` -> all outputs at reset values.
